lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16, LFSR state width, legal 3..32.
REQ-002 Parameter TAPS, default 16'hB400, feedback mask; bit i set means q[i] participates in feedback.
REQ-003 Parameter MODE, default 0, structure select: 0 = Fibonacci, 1 = Galois.
REQ-004 Parameter STEPS, default 1, LFSR shifts per accepted output word, legal 1..WIDTH.
REQ-005 Parameter DEFAULT_SEED, default 1, non-zero state used at reset and for lock-up recovery.
REQ-006 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1, asynchronous, active-high.
REQ-008 Port en, input, 1, generator enable; when low, no advance and out_valid low.
REQ-009 Port load, input, 1, one-cycle seed load strobe.
REQ-010 Port seed, input, WIDTH, value captured on load.
REQ-011 Port out_ready, input, 1, consumer accepts out_data.
REQ-012 Port out_valid, output, 1, out_data holds a valid word.
REQ-013 Port out_data, output, WIDTH, current LFSR state.
REQ-014 Port wrap, output, 1, one-cycle pulse when the state returns to the last loaded seed.
REQ-015 Port lockup, output, 1, one-cycle pulse when an all-zero seed was replaced.
REQ-016 Port step_count, output, 32, accepted transfers since the last load or reset, saturating at all-ones.

Function
REQ-017 The FSM shall have two states, IDLE and RUN, with reset entering IDLE.
REQ-018 IDLE shall go to RUN when en=1; RUN shall go to IDLE when en=0; a load shall not change the FSM state.
REQ-019 out_valid shall be 1 only in RUN with en=1 and load=0; out_data shall equal the state register.
REQ-020 A transfer shall occur when out_valid and out_ready are both 1; the state shall then advance STEPS shifts in one cycle, so the next word is visible the next cycle.
REQ-021 Without a transfer, the state, out_data and step_count shall hold.
REQ-022 Fibonacci single shift: fb = XOR of q[i] where TAPS[i]=1; next = {q[WIDTH-2:0], fb}.
REQ-023 Galois single shift: m = q[WIDTH-1]; next[0] = m; next[i] = q[i-1] XOR (TAPS[i-1] AND m) for i = 1..WIDTH-1.
REQ-024 load=1 shall have priority over a transfer; the state and the wrap reference shall take seed, or DEFAULT_SEED if seed==0, and step_count shall clear.
REQ-025 If a load carries seed==0, lockup shall pulse on the following cycle.
REQ-026 If the post-advance state equals the wrap reference, wrap shall pulse in the cycle that state appears on out_data.
REQ-027 step_count shall increment by 1 per transfer and hold at 32'hFFFFFFFF.

Reset
REQ-028 Reset shall give: state = DEFAULT_SEED, wrap reference = DEFAULT_SEED, FSM = IDLE, out_valid = 0, wrap = 0, lockup = 0, step_count = 0.
REQ-029 Reset asserted mid-operation shall abort immediately with no partial advance; after reset release, the first word after en shall be DEFAULT_SEED.

Structure
REQ-030 The FSM state enum and the MODE encodings (FIB=0, GAL=1) shall live in the shared package lfsr_pkg.
REQ-031 The single-shift function for one MODE shall be the sub-module lfsr_step, which shall be instantiated STEPS times in a combinational chain.
REQ-032 TAPS==0, or STEPS outside 1..WIDTH, shall be rejected at elaboration.

Verification
REQ-033 WIDTH=5, TAPS=5'b10100, MODE=0, STEPS=1, ready held 1 -> out_data 00001, 00010, 00100, 01001, 10010, 00101 ...; wrap pulses after 31 transfers; step_count=31.
REQ-034 Same configuration with out_ready toggled randomly -> identical word sequence, with no word skipped or repeated across stalls.
REQ-035 load with seed=0 -> out_data=DEFAULT_SEED, lockup pulses once, step_count=0.
REQ-036 MODE=1, WIDTH=5, TAPS=5'b00100, seed 00001 -> 31 distinct non-zero states, then wrap; the all-zero state never occurs.
REQ-037 STEPS=4 versus STEPS=1 on the same seed -> each STEPS=4 word equals every 4th STEPS=1 word.
REQ-038 reset asserted mid-stream while out_ready=1 -> out_valid drops in the same cycle; after release with en=1, the first word is DEFAULT_SEED.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR generator: FSM state encoding,
// structure-select codes and a saturating counter helper.
package lfsr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR shift, Fibonacci or Galois form selected by MODE.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter int               MODE  = MODE_FIB
) (
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_q
);

  genvar gi;

  generate
    if (MODE == MODE_FIB) begin : g_fib
      logic w_fb;
      assign w_fb = ^(i_q & TAPS);
      assign o_q  = {i_q[WIDTH-2:0], w_fb};
    end else begin : g_gal
      logic w_msb;
      assign w_msb  = i_q[WIDTH-1];
      assign o_q[0] = w_msb;
      // The outgoing MSB is folded into every tapped position as it shifts up.
      for (gi = 1; gi < WIDTH; gi++) begin : g_bit
        assign o_q[gi] = i_q[gi-1] ^ (TAPS[gi-1] & w_msb);
      end
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR word generator with valid/ready output, seed load, lock-up recovery,
// wrap detection and a saturating transfer counter.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter int               MODE         = MODE_FIB,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             wrap,
  output logic             lockup,
  output logic [31:0]      step_count
);

  genvar gi;

  generate
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (TAPS == '0) begin : g_bad_taps
      $error("lfsr_gen: TAPS must not be zero");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
      $error("lfsr_gen: STEPS must be in 1..WIDTH");
    end
    if (MODE != MODE_FIB && MODE != MODE_GAL) begin : g_bad_mode
      $error("lfsr_gen: MODE must be 0 (Fibonacci) or 1 (Galois)");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: DEFAULT_SEED must be non-zero");
    end
  endgenerate

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_ref;
  fsm_state_t       r_fsm;
  logic             r_wrap;
  logic             r_lockup;
  logic [31:0]      r_step_count;

  logic [WIDTH-1:0] w_adv;
  logic [WIDTH-1:0] w_load_val;
  logic             w_valid;
  logic             w_xfer;

  // STEPS single-shift stages chained so a whole word advances in one cycle.
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_step
      logic [WIDTH-1:0] w_in;
      logic [WIDTH-1:0] w_out;
      if (gi == 0) begin : g_first
        assign w_in = r_state;
      end else begin : g_next
        assign w_in = g_step[gi-1].w_out;
      end
      lfsr_step #(
        .WIDTH(WIDTH),
        .TAPS (TAPS),
        .MODE (MODE)
      ) u_step (
        .i_q(w_in),
        .o_q(w_out)
      );
    end
  endgenerate

  assign w_adv      = g_step[STEPS-1].w_out;
  assign w_load_val = (seed == '0) ? DEFAULT_SEED : seed;
  assign w_valid    = (r_fsm == ST_RUN) && en && !load;
  assign w_xfer     = w_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= DEFAULT_SEED;
      r_ref        <= DEFAULT_SEED;
      r_fsm        <= ST_IDLE;
      r_wrap       <= 1'b0;
      r_lockup     <= 1'b0;
      r_step_count <= 32'd0;
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;

      if (r_fsm == ST_IDLE) begin
        if (en) r_fsm <= ST_RUN;
      end else begin
        if (!en) r_fsm <= ST_IDLE;
      end

      if (load) begin
        r_state      <= w_load_val;
        r_ref        <= w_load_val;
        r_step_count <= 32'd0;
        r_lockup     <= (seed == '0);
      end else if (w_xfer) begin
        r_state      <= w_adv;
        r_wrap       <= (w_adv == r_ref);
        r_step_count <= sat_inc32(r_step_count);
      end
    end
  end

  assign out_valid  = w_valid;
  assign out_data   = r_state;
  assign wrap       = r_wrap;
  assign lockup     = r_lockup;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: Fibonacci STEPS=1, Fibonacci STEPS=4 and
// Galois instances, driven from shared control with per-instance ready.
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en;
  logic       load;
  logic [4:0] seed;
  logic       rdy_f, rdy_s, rdy_g;

  logic        v_f, w_f, l_f;
  logic [4:0]  d_f;
  logic [31:0] c_f;
  logic        v_s, w_s, l_s;
  logic [4:0]  d_s;
  logic [31:0] c_s;
  logic        v_g, w_g, l_g;
  logic [4:0]  d_g;
  logic [31:0] c_g;

  lfsr_gen #(.WIDTH(5), .TAPS(5'b10100), .MODE(0), .STEPS(1)) dut_fib (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed),
    .out_ready(rdy_f), .out_valid(v_f), .out_data(d_f), .wrap(w_f),
    .lockup(l_f), .step_count(c_f)
  );

  lfsr_gen #(.WIDTH(5), .TAPS(5'b10100), .MODE(0), .STEPS(4)) dut_s4 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed),
    .out_ready(rdy_s), .out_valid(v_s), .out_data(d_s), .wrap(w_s),
    .lockup(l_s), .step_count(c_s)
  );

  lfsr_gen #(.WIDTH(5), .TAPS(5'b00100), .MODE(1), .STEPS(1)) dut_gal (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed),
    .out_ready(rdy_g), .out_valid(v_g), .out_data(d_g), .wrap(w_g),
    .lockup(l_g), .step_count(c_g)
  );

  // Hand-computed Fibonacci sequence for x^5 taps {4,2} from seed 00001.
  logic [4:0] fib_seq [0:30] = '{
    5'd1,  5'd2,  5'd4,  5'd9,  5'd18, 5'd5,  5'd11, 5'd22,
    5'd12, 5'd25, 5'd19, 5'd7,  5'd15, 5'd31, 5'd30, 5'd28,
    5'd24, 5'd17, 5'd3,  5'd6,  5'd13, 5'd27, 5'd23, 5'd14,
    5'd29, 5'd26, 5'd21, 5'd10, 5'd20, 5'd8,  5'd16
  };
  // Hand-computed first Galois words for taps 00100 from seed 00001.
  logic [4:0] gal_head [0:7] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd9, 5'd18, 5'd13};

  typedef struct {
    logic        rdy;
    logic [4:0]  exp_data;
    logic        exp_wrap;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [0:31];
  logic seen [0:31];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          idx;
  int          exp_cnt;
  logic        xfer;
  logic [4:0]  held;

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; seed = 5'd0;
    rdy_f = 1'b1; rdy_s = 1'b1; rdy_g = 1'b1;
    for (int i = 0; i < 32; i++) begin
      vecs[i] = '{1'b1, fib_seq[i % 31], (i == 31), 32'(i)};
      seen[i] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(v_f), 32'd0);
    chk("rst_data", 32'(d_f), 32'd1);
    chk("rst_wrap", 32'(w_f), 32'd0);
    chk("rst_lockup", 32'(l_f), 32'd0);
    chk("rst_count", c_f, 32'd0);
    chk("rst_gal_data", 32'(d_g), 32'd1);

    reset = 1'b0;
    en    = 1'b1;
    #1;
    chk("idle_valid", 32'(v_f), 32'd0);
    tick();

    // Full period with ready held high on all three instances.
    for (int i = 0; i < 32; i++) begin
      rdy_f = vecs[i].rdy;
      #1;
      chk("fib_valid", 32'(v_f), 32'd1);
      chk("fib_data", 32'(d_f), 32'(vecs[i].exp_data));
      chk("fib_wrap", 32'(w_f), 32'(vecs[i].exp_wrap));
      chk("fib_count", c_f, vecs[i].exp_cnt);
      if (i < 8) chk("s4_data", 32'(d_s), 32'(fib_seq[(4 * i) % 31]));
      chk("s4_wrap", 32'(w_s), 32'(i == 31));
      if (i < 8) chk("gal_head", 32'(d_g), 32'(gal_head[i]));
      if (i < 31) begin
        chk("gal_nonzero", 32'(d_g != 5'd0), 32'd1);
        chk("gal_distinct", 32'(seen[d_g]), 32'd0);
        seen[d_g] = 1'b1;
        chk("gal_wrap", 32'(w_g), 32'd0);
      end else begin
        chk("gal_wrap_data", 32'(d_g), 32'd1);
        chk("gal_wrap", 32'(w_g), 32'd1);
        chk("gal_count", c_g, 32'd31);
      end
      tick();
    end

    rdy_f = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", 32'(d_f), 32'(fib_seq[1]));
      chk("stall_count", c_f, 32'd32);
      chk("stall_wrap", 32'(w_f), 32'd0);
    end

    // Zero seed is replaced by the default seed and flagged.
    rdy_f = 1'b1; load = 1'b1; seed = 5'd0;
    #1;
    chk("load_valid", 32'(v_f), 32'd0);
    tick();
    load = 1'b0;
    #1;
    chk("lock_data", 32'(d_f), 32'd1);
    chk("lock_pulse", 32'(l_f), 32'd1);
    chk("lock_count", c_f, 32'd0);
    tick();
    chk("lock_clear", 32'(l_f), 32'd0);
    chk("lock_next", 32'(d_f), 32'd2);
    chk("lock_count1", c_f, 32'd1);

    load = 1'b1; seed = 5'b10110;
    tick();
    load = 1'b0;
    chk("seed_data", 32'(d_f), 32'd22);
    chk("seed_lockup", 32'(l_f), 32'd0);
    chk("seed_count", c_f, 32'd0);

    // Random stalls: the sequence must continue without skips or repeats.
    idx = 7;
    exp_cnt = 0;
    for (int n = 0; n < 120; n++) begin
      rdy_f = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_valid", 32'(v_f), 32'd1);
      xfer = rdy_f;
      tick();
      if (xfer) begin
        idx = (idx + 1) % 31;
        exp_cnt++;
      end
      chk("rnd_data", 32'(d_f), 32'(fib_seq[idx]));
      chk("rnd_wrap", 32'(w_f), 32'(xfer && idx == 7));
      chk("rnd_count", c_f, 32'(exp_cnt));
    end

    held = fib_seq[idx];
    en = 1'b0;
    #1;
    chk("en_low_valid", 32'(v_f), 32'd0);
    tick();
    chk("en_low_hold", 32'(d_f), 32'(held));
    en = 1'b1;
    #1;
    chk("reidle_valid", 32'(v_f), 32'd0);
    tick();
    chk("rerun_valid", 32'(v_f), 32'd1);
    chk("rerun_data", 32'(d_f), 32'(held));

    // Asynchronous reset in the middle of a running stream.
    rdy_f = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(v_f), 32'd0);
    chk("mid_rst_data", 32'(d_f), 32'd1);
    chk("mid_rst_count", c_f, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_idle", 32'(v_f), 32'd0);
    tick();
    chk("post_rst_valid", 32'(v_f), 32'd1);
    chk("post_rst_data", 32'(d_f), 32'd1);
    tick();
    chk("post_rst_next", 32'(d_f), 32'd2);
    chk("post_rst_count", c_f, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
